tile_ring_fifo: RTL

Parametrised per-dimension router FIFO for the tile mesh. Each instance sits on one axis (X or Y) of a tile and carries flits in both directions along that axis. It buffers transit traffic in per-direction FIFOs, ejects flits addressed to this tile into a local delivery port, and injects local flits toward the correct direction. Every link uses valid/ready backpressure, and the inject port has starvation protection.

---
 rtl/tile_ring_fifo.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/tile_ring_fifo.sv
// Generic ring-buffer FIFO for one flit stream.
// Latency: a pushed entry is visible at the head one cycle later.
// Backpressure: a push is taken only while not full (by registered count); a push into a full FIFO is dropped.
module ring_fifo_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_vld,
    input  logic [W-1:0]           push_dat,
    output logic                   pop_vld,
    output logic [W-1:0]           pop_dat,
    input  logic                   pop_rdy,
    output logic [$clog2(DEPTH):0] cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign pop_vld = (cnt_q != '0);
    assign pop_dat = mem_q[rd_q];
    assign cnt     = cnt_q;
    assign do_push = push_vld & (cnt_q != FULL_CNT);
    assign do_pop  = pop_rdy & pop_vld;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = push_dat;
            wr_d        = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// Per-axis router FIFO: transit buffering both ways, local eject merge, local inject with starvation guard.
// Latency: transit/eject/loopback one cycle through a FIFO; non-loopback inject passes through in zero cycles.
// Backpressure: valid/ready on every link; in_ready reflects the target FIFO's registered fullness.
module tile_ring_fifo #(
    parameter int DW     = 592,
    parameter int CW     = 2,
    parameter int DEPTH  = 8,
    parameter int TILE_C = 0,
    parameter int STARVE = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [1:0]                      in_valid,
    input  logic [1:0][CW+DW-1:0]           in_flit,
    output logic [1:0]                      in_ready,
    output logic [1:0]                      out_valid,
    output logic [1:0][CW+DW-1:0]           out_flit,
    input  logic [1:0]                      out_ready,
    input  logic                            inj_valid,
    input  logic [CW+DW-1:0]                inj_flit,
    output logic                            inj_ready,
    output logic                            ej_valid,
    output logic [CW+DW-1:0]                ej_flit,
    input  logic                            ej_ready,
    output logic [1:0][$clog2(DEPTH):0]     occ
);
    localparam int CNTW = $clog2(DEPTH) + 1;
    localparam int SW   = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
    localparam logic [CW-1:0]   TILE     = CW'(TILE_C);
    localparam logic [SW-1:0]   STARVE_V = SW'(STARVE);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

    typedef struct packed {
        logic [CW-1:0] dst;
        logic [DW-1:0] payload;
    } flit_t;

    flit_t [1:0]           arr;
    flit_t                 inj;
    flit_t [1:0]           t_head;
    flit_t [1:0]           e_head;
    flit_t [1:0]           e_push_dat;
    logic  [1:0]           arr_local;
    logic  [1:0]           t_push_vld;
    logic  [1:0]           e_push_vld;
    logic  [1:0]           t_push_rdy;
    logic  [1:0]           e_push_rdy;
    logic  [1:0]           t_pop_vld;
    logic  [1:0]           e_pop_vld;
    logic  [1:0]           t_pop_rdy;
    logic  [1:0]           e_pop_rdy;
    logic  [1:0][CNTW-1:0] t_cnt;
    logic  [1:0][CNTW-1:0] e_cnt;
    logic                  inj_loop;
    logic                  inj_dir;
    logic  [1:0]           inj_tgt;
    logic  [1:0]           inj_win;
    logic  [1:0][SW-1:0]   s_q, s_d;
    logic                  p_q, p_d;
    logic                  ej_sel;

    assign arr = in_flit;
    assign inj = inj_flit;
    assign occ = t_cnt;

    for (genvar d = 0; d < 2; d++) begin : g_dir
        ring_fifo_buf #(.W(CW+DW), .DEPTH(DEPTH)) u_transit (
            .clk      (clk),
            .rst      (rst),
            .push_vld (t_push_vld[d]),
            .push_dat (arr[d]),
            .pop_vld  (t_pop_vld[d]),
            .pop_dat  (t_head[d]),
            .pop_rdy  (t_pop_rdy[d]),
            .cnt      (t_cnt[d])
        );

        ring_fifo_buf #(.W(CW+DW), .DEPTH(DEPTH)) u_eject (
            .clk      (clk),
            .rst      (rst),
            .push_vld (e_push_vld[d]),
            .push_dat (e_push_dat[d]),
            .pop_vld  (e_pop_vld[d]),
            .pop_dat  (e_head[d]),
            .pop_rdy  (e_pop_rdy[d]),
            .cnt      (e_cnt[d])
        );
    end

    // Arrival steering; a loopback inject may only use E[0] when no arrival claims it.
    always_comb begin
        inj_loop = (inj.dst == TILE);
        inj_dir  = (inj.dst > TILE);
        for (int d = 0; d < 2; d++) begin
            arr_local[d]  = (arr[d].dst == TILE);
            t_push_rdy[d] = (t_cnt[d] != FULL_CNT);
            e_push_rdy[d] = (e_cnt[d] != FULL_CNT);
            t_push_vld[d] = in_valid[d] & ~arr_local[d];
            e_push_vld[d] = in_valid[d] & arr_local[d];
            e_push_dat[d] = arr[d];
            in_ready[d]   = arr_local[d] ? e_push_rdy[d] : t_push_rdy[d];
        end
        if (inj_valid & inj_loop & ~e_push_vld[0]) begin
            e_push_vld[0] = 1'b1;
            e_push_dat[0] = inj;
        end
    end

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            inj_tgt[d]   = inj_valid & ~inj_loop & (inj_dir == 1'(d));
            inj_win[d]   = inj_tgt[d] & (~t_pop_vld[d] | (s_q[d] == STARVE_V));
            out_valid[d] = t_pop_vld[d] | inj_tgt[d];
            out_flit[d]  = inj_win[d] ? inj : t_head[d];
            t_pop_rdy[d] = out_ready[d] & ~inj_win[d];
            s_d[d]       = s_q[d];
            if (!inj_tgt[d]) begin
                s_d[d] = '0;
            end else if (out_ready[d]) begin
                s_d[d] = inj_win[d] ? '0 : s_q[d] + 1'b1;
            end
        end
    end

    always_comb begin
        if (inj_loop) begin
            inj_ready = inj_valid & e_push_rdy[0] & ~(in_valid[0] & arr_local[0]);
        end else begin
            inj_ready = inj_valid & out_ready[inj_dir] & inj_win[inj_dir];
        end
    end

    // Round-robin only matters when both eject FIFOs hold data.
    always_comb begin
        if (e_pop_vld[0] & e_pop_vld[1]) begin
            ej_sel = p_q;
        end else begin
            ej_sel = e_pop_vld[1];
        end
        ej_valid          = |e_pop_vld;
        ej_flit           = e_head[ej_sel];
        e_pop_rdy         = '0;
        e_pop_rdy[ej_sel] = ej_ready;
        p_d               = p_q;
        if (ej_valid & ej_ready) begin
            p_d = ~ej_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= '0;
            p_q <= 1'b0;
        end else begin
            s_q <= s_d;
            p_q <= p_d;
        end
    end
endmodule
